// File: rtl/ps2_dir_decoder.sv
// PS/2 keyboard frame receiver that turns arrow keys and the WASD-style letter keys into one-cycle move commands.
// Latency: the pulse appears 2 clk cycles after the stop-bit edge is detected. There is no backpressure; a pulse is dropped if nobody samples it.
module ps2_dir_decoder #(
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic       clk,
    input  logic       clrn,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       dir_valid,
    output logic [1:0] dir,
    output logic       frame_err
);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic {S_IDLE, S_RECV} state_t;

    state_t          r_state;
    logic            r_clk_meta, r_clk_sync, r_clk_prev;
    logic            r_dat_meta, r_dat_sync;
    logic [3:0]      r_bitcnt;
    logic [7:0]      r_shift;
    logic            r_par;
    logic [TW-1:0]   r_tmo;
    logic            r_byte_vld, r_err_pend;
    logic            r_e0, r_f0, r_held_vld;
    logic [1:0]      r_held_dir;

    logic            w_fall;
    logic            w_map_vld;
    logic [1:0]      w_map_dir;

    assign w_fall = r_clk_prev & ~r_clk_sync;

    // Frame receiver; r_shift doubles as the received byte for the decode stage
    always_ff @(posedge clk) begin
        if (!clrn) begin
            r_clk_meta <= 1'b1;
            r_clk_sync <= 1'b1;
            r_clk_prev <= 1'b1;
            r_dat_meta <= 1'b1;
            r_dat_sync <= 1'b1;
            r_state    <= S_IDLE;
            r_bitcnt   <= '0;
            r_shift    <= '0;
            r_par      <= 1'b0;
            r_tmo      <= '0;
            r_byte_vld <= 1'b0;
            r_err_pend <= 1'b0;
        end else begin
            r_clk_meta <= ps2_clk;
            r_clk_sync <= r_clk_meta;
            r_clk_prev <= r_clk_sync;
            r_dat_meta <= ps2_data;
            r_dat_sync <= r_dat_meta;
            r_byte_vld <= 1'b0;
            r_err_pend <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_tmo <= '0;
                    if (w_fall && !r_dat_sync) begin
                        r_state  <= S_RECV;
                        r_bitcnt <= 4'd1;
                    end
                end
                S_RECV: begin
                    if (w_fall) begin
                        r_tmo <= '0;
                        if (r_bitcnt <= 4'd8) begin
                            r_shift  <= {r_dat_sync, r_shift[7:1]};
                            r_bitcnt <= r_bitcnt + 4'd1;
                        end else if (r_bitcnt == 4'd9) begin
                            r_par    <= r_dat_sync;
                            r_bitcnt <= 4'd10;
                        end else begin
                            r_state  <= S_IDLE;
                            r_bitcnt <= '0;
                            if ((^{r_shift, r_par}) && r_dat_sync)
                                r_byte_vld <= 1'b1;
                            else
                                r_err_pend <= 1'b1;
                        end
                    end else if (r_tmo == TW'(TIMEOUT_CYC - 1)) begin
                        r_state    <= S_IDLE;
                        r_bitcnt   <= '0;
                        r_shift    <= '0;
                        r_tmo      <= '0;
                        r_err_pend <= 1'b1;
                    end else begin
                        r_tmo <= r_tmo + 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Arrow codes need the E0 prefix; letter codes must arrive without it
    always_comb begin
        w_map_vld = 1'b0;
        w_map_dir = 2'b00;
        if (r_e0) begin
            case (r_shift)
                8'h75: begin w_map_vld = 1'b1; w_map_dir = 2'b00; end
                8'h72: begin w_map_vld = 1'b1; w_map_dir = 2'b01; end
                8'h6B: begin w_map_vld = 1'b1; w_map_dir = 2'b10; end
                8'h74: begin w_map_vld = 1'b1; w_map_dir = 2'b11; end
                default: ;
            endcase
        end else begin
            case (r_shift)
                8'h1D: begin w_map_vld = 1'b1; w_map_dir = 2'b00; end
                8'h1B: begin w_map_vld = 1'b1; w_map_dir = 2'b01; end
                8'h1C: begin w_map_vld = 1'b1; w_map_dir = 2'b10; end
                8'h23: begin w_map_vld = 1'b1; w_map_dir = 2'b11; end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!clrn) begin
            dir_valid  <= 1'b0;
            dir        <= 2'b00;
            frame_err  <= 1'b0;
            r_e0       <= 1'b0;
            r_f0       <= 1'b0;
            r_held_vld <= 1'b0;
            r_held_dir <= 2'b00;
        end else begin
            dir_valid <= 1'b0;
            frame_err <= 1'b0;
            if (r_err_pend) begin
                frame_err <= 1'b1;
                r_e0      <= 1'b0;
                r_f0      <= 1'b0;
            end else if (r_byte_vld) begin
                if (r_shift == 8'hE0) begin
                    r_e0 <= 1'b1;
                end else if (r_shift == 8'hF0) begin
                    r_f0 <= 1'b1;
                end else begin
                    r_e0 <= 1'b0;
                    r_f0 <= 1'b0;
                    if (w_map_vld) begin
                        if (r_f0) begin
                            if (r_held_dir == w_map_dir)
                                r_held_vld <= 1'b0;
                        end else if (!r_held_vld || r_held_dir != w_map_dir) begin
                            dir        <= w_map_dir;
                            dir_valid  <= 1'b1;
                            r_held_dir <= w_map_dir;
                            r_held_vld <= 1'b1;
                        end
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_ps2_dir_decoder.sv
// Directed bench: drives PS/2 frames at a slow bit rate and checks pulse timing, dir value and error pulses.
module tb_ps2_dir_decoder;
    localparam int TMO = 200;
    localparam int HB  = 4;

    logic       clk = 1'b0;
    logic       clrn = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic       dir_valid;
    logic [1:0] dir;
    logic       frame_err;

    int total = 0;
    int bad = 0;
    int dv_cnt = 0;
    int er_cnt = 0;
    int both_cnt = 0;
    int dv0, er0;

    ps2_dir_decoder #(.TIMEOUT_CYC(TMO)) dut (
        .clk(clk), .clrn(clrn), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .dir_valid(dir_valid), .dir(dir), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (dir_valid === 1'b1) dv_cnt++;
        if (frame_err === 1'b1) er_cnt++;
        if (dir_valid === 1'b1 && frame_err === 1'b1) both_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_partial(input logic [7:0] b, input int n);
        logic [10:0] f;
        f = {1'b1, ~^b, b, 1'b0};
        for (int i = 0; i < n; i++) begin
            @(negedge clk) ps2_data = f[i];
            repeat (HB) @(negedge clk);
            ps2_clk = 1'b0;
            repeat (HB) @(negedge clk);
            ps2_clk = 1'b1;
        end
        repeat (HB) @(negedge clk);
    endtask

    // Stop-bit low is applied at a negedge; the pulse is expected on the 4th negedge after it
    task automatic send_frame(input string tag, input logic [7:0] b, input bit flip,
                              input bit ev, input bit ee, input logic [1:0] ed);
        logic [10:0] f;
        f = {1'b1, (~^b) ^ flip, b, 1'b0};
        for (int i = 0; i < 11; i++) begin
            @(negedge clk) ps2_data = f[i];
            repeat (HB) @(negedge clk);
            ps2_clk = 1'b0;
            if (i == 10) begin
                repeat (3) @(negedge clk);
                chk({tag, "_early_dv"}, 32'(dir_valid), 32'd0);
                chk({tag, "_early_err"}, 32'(frame_err), 32'd0);
                @(negedge clk);
                chk({tag, "_dv"}, 32'(dir_valid), 32'(ev));
                chk({tag, "_err"}, 32'(frame_err), 32'(ee));
                if (ev) chk({tag, "_dir"}, 32'(dir), 32'(ed));
                @(negedge clk);
                chk({tag, "_width"}, 32'({dir_valid, frame_err}), 32'd0);
            end else begin
                repeat (HB) @(negedge clk);
            end
            ps2_clk = 1'b1;
        end
        repeat (HB) @(negedge clk);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_dv", 32'(dir_valid), 32'd0);
        chk("rst_dir", 32'(dir), 32'd0);
        chk("rst_err", 32'(frame_err), 32'd0);
        clrn = 1'b1;
        repeat (5) @(negedge clk);
        chk("post_rst_quiet", 32'(dv_cnt + er_cnt), 32'd0);

        send_frame("e0_pre", 8'hE0, 0, 0, 0, 2'b00);
        send_frame("up_arrow", 8'h75, 0, 1, 0, 2'b00);

        send_frame("left_1", 8'h1C, 0, 1, 0, 2'b10);
        send_frame("left_rep2", 8'h1C, 0, 0, 0, 2'b10);
        send_frame("left_rep3", 8'h1C, 0, 0, 0, 2'b10);
        send_frame("f0_pre", 8'hF0, 0, 0, 0, 2'b00);
        send_frame("left_brk", 8'h1C, 0, 0, 0, 2'b10);
        send_frame("left_again", 8'h1C, 0, 1, 0, 2'b10);

        send_frame("right_badpar", 8'h23, 1, 0, 1, 2'b11);
        send_frame("right_ok", 8'h23, 0, 1, 0, 2'b11);

        send_frame("unmapped_75", 8'h75, 0, 0, 0, 2'b00);
        send_frame("e0_pre2", 8'hE0, 0, 0, 0, 2'b00);
        send_frame("e0_letter", 8'h1D, 0, 0, 0, 2'b00);
        chk("dir_hold", 32'(dir), 32'd3);

        send_partial(8'h1B, 5);
        dv0 = dv_cnt;
        er0 = er_cnt;
        repeat (TMO + 60) @(negedge clk);
        chk("tmo_err_cnt", 32'(er_cnt - er0), 32'd1);
        chk("tmo_dv_cnt", 32'(dv_cnt - dv0), 32'd0);
        send_frame("down_letter", 8'h1B, 0, 1, 0, 2'b01);

        send_frame("right_set", 8'h23, 0, 1, 0, 2'b11);
        send_frame("e0_b", 8'hE0, 0, 0, 0, 2'b00);
        send_frame("f0_b", 8'hF0, 0, 0, 0, 2'b00);
        send_frame("right_brk", 8'h74, 0, 0, 0, 2'b11);
        send_frame("e0_c", 8'hE0, 0, 0, 0, 2'b00);
        send_frame("right_arrow", 8'h74, 0, 1, 0, 2'b11);
        send_frame("e0_d", 8'hE0, 0, 0, 0, 2'b00);
        send_frame("down_arrow", 8'h72, 0, 1, 0, 2'b01);

        send_partial(8'h1D, 4);
        er0 = er_cnt;
        @(negedge clk) clrn = 1'b0;
        @(negedge clk);
        chk("mid_rst_dv", 32'(dir_valid), 32'd0);
        chk("mid_rst_dir", 32'(dir), 32'd0);
        chk("mid_rst_err", 32'(frame_err), 32'd0);
        clrn = 1'b1;
        repeat (TMO + 20) @(negedge clk);
        chk("mid_rst_no_err", 32'(er_cnt - er0), 32'd0);
        send_frame("up_letter", 8'h1D, 0, 1, 0, 2'b00);

        chk("total_dv", 32'(dv_cnt), 32'd9);
        chk("total_err", 32'(er_cnt), 32'd2);
        chk("never_both", 32'(both_cnt), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/ps2_dir_decoder.md
PS2_DIR_DECODER -- requirements
Module: ps2_dir_decoder

Interface
REQ-001 Parameter TIMEOUT_CYC, default 50000: clk cycles without a ps2_clk falling edge before a partial frame is abandoned.
REQ-002 clk  input  1  system clock; all state updates on its rising edge.
REQ-003 clrn  input  1  reset, synchronous, active-low; sampled on the rising edge of clk.
REQ-004 ps2_clk  input  1  raw PS/2 keyboard clock, asynchronous to clk.
REQ-005 ps2_data  input  1  raw PS/2 keyboard data, asynchronous to clk.
REQ-006 dir_valid  output  1  one-cycle pulse: a new move command is on dir.
REQ-007 dir  output  2  move command: 00 up, 01 down, 10 left, 11 right; held until the next dir_valid.
REQ-008 frame_err  output  1  one-cycle pulse: a received frame had a bad start, parity or stop bit, or timed out.

Function
REQ-009 ps2_clk and ps2_data SHALL pass through 2-flop synchronizers; a falling edge is previous synchronized clk = 1 and current = 0.
REQ-010 Frame receiver FSM states: IDLE, RECV; bit counter 0..10; data captured from synchronized ps2_data on each falling edge.
REQ-011 IDLE -> RECV on a falling edge with data = 0 (start bit), counter = 1; a falling edge with data = 1 in IDLE is ignored, no error.
REQ-012 RECV: bits 1..8 shift into the byte LSB-first; bit 9 is parity; bit 10 is stop; after bit 10 -> IDLE.
REQ-013 Frame valid when parity is odd over data+parity and stop = 1; otherwise frame_err pulses and the byte is discarded.
REQ-014 Timeout counter clears on every falling edge; in RECV, reaching TIMEOUT_CYC -> IDLE, frame_err pulses, counter and partial byte discarded.
REQ-015 Byte layer keeps flags e0_seen and f0_seen: byte E0 sets e0_seen; F0 sets f0_seen; any other byte is decoded, then both flags clear.
REQ-016 Any frame error or timeout SHALL clear e0_seen and f0_seen.
REQ-017 Make-code map: E0 75 or 1D -> up; E0 72 or 1B -> down; E0 6B or 1C -> left; E0 74 or 23 -> right.
REQ-018 Arrow codes count only with e0_seen = 1; letter codes only with e0_seen = 0; all other codes are ignored.
REQ-019 Unmapped code: no dir_valid; it SHALL NOT change held-key state.
REQ-020 Held-key register (held_valid, held_dir): a mapped make with held_valid = 0 or held_dir != mapped dir drives dir, pulses dir_valid, and sets held_dir.
REQ-021 A mapped make equal to held_dir with held_valid = 1 (typematic repeat) SHALL produce no pulse.
REQ-022 A mapped break (f0_seen = 1) whose dir equals held_dir clears held_valid; other breaks are ignored; breaks never pulse dir_valid.
REQ-023 Latency: dir_valid or frame_err SHALL assert exactly 2 clk cycles after the cycle in which the stop-bit falling edge is detected.
REQ-024 Each pulse SHALL be exactly 1 cycle wide; dir_valid and frame_err SHALL never be high in the same cycle.
REQ-025 Only registered outputs; no combinational path from inputs to outputs.

Reset
REQ-026 clrn = 0 at a clk edge: dir_valid = 0, dir = 00, frame_err = 0; FSM = IDLE; counter, byte, timeout = 0; e0_seen, f0_seen, held_valid = 0.
REQ-027 Reset in mid-frame SHALL discard the partial frame with no frame_err; the next start bit after clrn = 1 begins a fresh frame.
REQ-028 Synchronizer flops reset to 1 (PS/2 idle), so no false falling edge on the cycle after reset release.

Verification
REQ-029 Frames E0, 75 (valid parity, 10 kHz ps2_clk) -> one dir_valid with dir = 00, 2 cycles after the 75 stop edge.
REQ-030 Frames 1C, 1C, 1C -> exactly one dir_valid (dir = 10); then F0, 1C, 1C -> a second dir_valid (dir = 10).
REQ-031 Frame 23 with parity bit flipped -> frame_err pulse, no dir_valid; next valid 23 -> dir_valid with dir = 11.
REQ-032 Send 5 bits of a frame, stop ps2_clk for TIMEOUT_CYC cycles -> single frame_err; next full frame 1B -> dir_valid with dir = 01.
REQ-033 Frames E0, F0, 74 with held_dir = right -> held_valid clears, no pulse; then E0, 72 -> dir_valid with dir = 01.
REQ-034 clrn low for 1 cycle in the middle of frame 1D -> all outputs 0, no frame_err; next full 1D frame -> dir_valid with dir = 00.
